coin_acceptor: RTL and testbench



---
 rtl/coin_acceptor_if.sv | 31 +++
 rtl/coin_acceptor.sv | 182 ++++++++++++++++++
 tb/tb_coin_acceptor.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/coin_acceptor_if.sv
// Coin-slot sensor and credit bus between the slot hardware, the acceptor and the vending FSM.
// The slot side drives sensors and accept_en; the acceptor drives credits and jam status.
interface coin_acceptor_if;
    logic nickel_raw;
    logic dime_raw;
    logic accept_en;
    logic N;
    logic D;
    logic coin_return;
    logic jam;

    modport master (
        output nickel_raw,
        output dime_raw,
        output accept_en,
        input  N,
        input  D,
        input  coin_return,
        input  jam
    );

    modport slave (
        input  nickel_raw,
        input  dime_raw,
        input  accept_en,
        output N,
        output D,
        output coin_return,
        output jam
    );
endinterface

// File: rtl/coin_acceptor.sv
// Coin validator: synchronises and debounces the nickel/dime sensors, detects jams and
// issues one credit or coin_return pulse per qualified coin.
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input  logic           clk,
    input  logic           rst,
    coin_acceptor_if.slave bus
);

    localparam int unsigned CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] JAM_MAX  = CW'(JAM_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_EMIT     = 3'd2,
        S_RELEASE  = 3'd3,
        S_JAM      = 3'd4
    } state_t;

    typedef enum logic {
        T_NICKEL = 1'b0,
        T_DIME   = 1'b1
    } coin_t;

    // Two-flop synchronisers; the FSM only ever looks at r_s_n / r_s_d.
    logic r_n_meta;
    logic r_s_n;
    logic r_d_meta;
    logic r_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_meta <= 1'b0;
            r_s_n    <= 1'b0;
            r_d_meta <= 1'b0;
            r_s_d    <= 1'b0;
        end else begin
            r_n_meta <= bus.nickel_raw;
            r_s_n    <= r_n_meta;
            r_d_meta <= bus.dime_raw;
            r_s_d    <= r_d_meta;
        end
    end

    state_t        r_state;
    logic [CW-1:0] r_lo_cnt;
    logic [CW-1:0] r_hi_cnt;
    coin_t         r_type;
    logic          r_acc;

    state_t        w_state_nxt;
    logic [CW-1:0] w_lo_nxt;
    logic [CW-1:0] w_hi_nxt;
    coin_t         w_type_nxt;
    logic          w_acc_nxt;

    logic w_lat_s;
    logic w_oth_s;
    logic w_any_hi;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    assign w_lat_s  = (r_type == T_NICKEL) ? r_s_n : r_s_d;
    assign w_oth_s  = (r_type == T_NICKEL) ? r_s_d : r_s_n;
    assign w_any_hi = r_s_n | r_s_d;

    // Next-state and counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo_cnt;
        w_hi_nxt    = r_hi_cnt;
        w_type_nxt  = r_type;
        w_acc_nxt   = r_acc;

        case (r_state)
            S_IDLE: begin
                if (r_s_n && r_s_d) begin
                    w_state_nxt = S_JAM;
                    w_lo_nxt    = '0;
                end else if (r_s_n ^ r_s_d) begin
                    w_type_nxt  = r_s_d ? T_DIME : T_NICKEL;
                    w_hi_nxt    = CW'(1);
                    w_state_nxt = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                if (!w_lat_s) begin
                    w_state_nxt = S_IDLE;
                end else if (w_oth_s) begin
                    w_state_nxt = S_JAM;
                    w_lo_nxt    = '0;
                end else if (r_hi_cnt == DEB_LAST) begin
                    w_acc_nxt   = bus.accept_en;
                    w_state_nxt = S_EMIT;
                end else begin
                    w_hi_nxt = sat_inc(r_hi_cnt);
                end
            end

            S_EMIT: begin
                w_state_nxt = S_RELEASE;
                w_lo_nxt    = '0;
                w_hi_nxt    = DEB_MAX;
            end

            S_RELEASE: begin
                w_lo_nxt = w_any_hi ? '0 : sat_inc(r_lo_cnt);
                w_hi_nxt = w_any_hi ? sat_inc(r_hi_cnt) : r_hi_cnt;
                if (w_oth_s || (w_hi_nxt >= JAM_MAX)) begin
                    w_state_nxt = S_JAM;
                    w_lo_nxt    = '0;
                end else if (w_lo_nxt >= DEB_MAX) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_JAM: begin
                w_lo_nxt = w_any_hi ? '0 : sat_inc(r_lo_cnt);
                if (w_lo_nxt >= DEB_MAX) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_RELEASE;
                w_lo_nxt    = '0;
                w_hi_nxt    = '0;
            end
        endcase
    end

    // Reset parks in RELEASE so a coin held across reset must leave before anything is credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RELEASE;
            r_lo_cnt <= '0;
            r_hi_cnt <= '0;
            r_type   <= T_NICKEL;
            r_acc    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo_cnt <= w_lo_nxt;
            r_hi_cnt <= w_hi_nxt;
            r_type   <= w_type_nxt;
            r_acc    <= w_acc_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the EMIT/JAM states.
    logic r_n;
    logic r_d;
    logic r_cr;
    logic r_jam;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n   <= 1'b0;
            r_d   <= 1'b0;
            r_cr  <= 1'b0;
            r_jam <= 1'b0;
        end else begin
            r_n   <= (w_state_nxt == S_EMIT) && (w_type_nxt == T_NICKEL) && w_acc_nxt;
            r_d   <= (w_state_nxt == S_EMIT) && (w_type_nxt == T_DIME) && w_acc_nxt;
            r_cr  <= (w_state_nxt == S_EMIT) && !w_acc_nxt;
            r_jam <= (w_state_nxt == S_JAM);
        end
    end

    assign bus.N           = r_n;
    assign bus.D           = r_d;
    assign bus.coin_return = r_cr;
    assign bus.jam         = r_jam;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: per-edge sensor patterns with hand-computed pulse and jam timing.
module tb_coin_acceptor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    coin_acceptor_if bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(4),
        .JAM_CYCLES     (64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    int n_cnt, n_first, n_last;
    int d_cnt, d_first;
    int cr_cnt, cr_first;
    int jam_cnt, jam_first, jam_last;
    int rst_outs;
    int ovl = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [127:0] mk(input int s, input int len);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < 128; i++) begin
            if (i >= s && i < s + len) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Edge e samples np[e]/dp[e]/ap[e]; outputs are observed 1 time unit after edge e.
    task automatic run(input logic [127:0] np, input logic [127:0] dp, input logic [127:0] ap,
                       input int rst_edge, input int ncyc);
        n_cnt = 0;  n_first = -1;  n_last = -1;
        d_cnt = 0;  d_first = -1;
        cr_cnt = 0; cr_first = -1;
        jam_cnt = 0; jam_first = -1; jam_last = -1;
        rst_outs = -1;
        for (int e = 0; e < ncyc; e++) begin
            bus.nickel_raw = np[e];
            bus.dime_raw   = dp[e];
            bus.accept_en  = ap[e];
            rst            = (e == rst_edge);
            @(posedge clk);
            #1;
            if (bus.N) begin
                n_cnt++;
                if (n_first < 0) n_first = e;
                n_last = e;
            end
            if (bus.D) begin
                d_cnt++;
                if (d_first < 0) d_first = e;
            end
            if (bus.coin_return) begin
                cr_cnt++;
                if (cr_first < 0) cr_first = e;
            end
            if (bus.jam) begin
                jam_cnt++;
                if (jam_first < 0) jam_first = e;
                jam_last = e;
            end
            if (bus.N && bus.D) ovl++;
            if (e == rst_edge) rst_outs = int'({bus.N, bus.D, bus.coin_return, bus.jam});
        end
        rst            = 1'b0;
        bus.nickel_raw = 1'b0;
        bus.dime_raw   = 1'b0;
        bus.accept_en  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.nickel_raw = 1'b0;
        bus.dime_raw   = 1'b0;
        bus.accept_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_N",   int'(bus.N), 0);
        check_eq("reset_D",   int'(bus.D), 0);
        check_eq("reset_cr",  int'(bus.coin_return), 0);
        check_eq("reset_jam", int'(bus.jam), 0);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Nickel credit, then a second nickel arriving right as IDLE is re-entered.
        run(mk(0, 10) | mk(14, 6), '0, '1, -1, 30);
        check_eq("nick_n_cnt",   n_cnt, 2);
        check_eq("nick_n_first", n_first, 5);
        check_eq("nick_n_last",  n_last, 19);
        check_eq("nick_d_cnt",   d_cnt, 0);
        check_eq("nick_cr_cnt",  cr_cnt, 0);
        check_eq("nick_jam_cnt", jam_cnt, 0);

        // Two-cycle dime glitch ignored, later real dime credited.
        run('0, mk(0, 2) | mk(8, 6), '1, -1, 25);
        check_eq("glitch_d_cnt",   d_cnt, 1);
        check_eq("glitch_d_first", d_first, 13);
        check_eq("glitch_cr_cnt",  cr_cnt, 0);
        check_eq("glitch_n_cnt",   n_cnt, 0);
        check_eq("glitch_jam_cnt", jam_cnt, 0);

        // Dime rejected: accept_en low at the qualifying edge, raised during EMIT.
        run('0, mk(0, 8), ~mk(0, 6), -1, 20);
        check_eq("reject_cr_cnt",   cr_cnt, 1);
        check_eq("reject_cr_first", cr_first, 5);
        check_eq("reject_d_cnt",    d_cnt, 0);
        check_eq("reject_n_cnt",    n_cnt, 0);

        // Both sensors rise together.
        run(mk(0, 5), mk(0, 5), '1, -1, 16);
        check_eq("simul_jam_first", jam_first, 2);
        check_eq("simul_jam_last",  jam_last, 9);
        check_eq("simul_jam_cnt",   jam_cnt, 8);
        check_eq("simul_credits",   n_cnt + d_cnt, 0);

        // Dime appears while the credited nickel is still releasing.
        run(mk(0, 10), mk(7, 3), '1, -1, 22);
        check_eq("cross_n_cnt",     n_cnt, 1);
        check_eq("cross_n_first",   n_first, 5);
        check_eq("cross_jam_first", jam_first, 9);
        check_eq("cross_jam_last",  jam_last, 14);
        check_eq("cross_d_cnt",     d_cnt, 0);

        // Nickel stuck for 100 cycles.
        run(mk(0, 100), '0, '1, -1, 115);
        check_eq("stuck_n_cnt",     n_cnt, 1);
        check_eq("stuck_n_first",   n_first, 5);
        check_eq("stuck_jam_first", jam_first, 66);
        check_eq("stuck_jam_last",  jam_last, 104);
        check_eq("stuck_jam_cnt",   jam_cnt, 39);

        // Reset during DEBOUNCE with the coin still held; a later nickel is credited.
        run(mk(0, 24) | mk(32, 6), '0, '1, 3, 45);
        check_eq("rstmid_outs",    rst_outs, 0);
        check_eq("rstmid_n_cnt",   n_cnt, 1);
        check_eq("rstmid_n_first", n_first, 37);
        check_eq("rstmid_jam_cnt", jam_cnt, 0);

        check_eq("n_d_overlap", ovl, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
